// File: rtl/mcpu_pkg.sv
// Shared types and helpers for the MCPU register file.
// Provides state encoding, default sizes and an address range check.
package mcpu_pkg;

    typedef enum logic [0:0] {
        RF_INIT = 1'b0,
        RF_RUN  = 1'b1
    } rf_state_t;

    localparam int MCPU_WIDTH = 16;
    localparam int MCPU_NREGS = 8;

    function automatic logic addr_valid(
        input logic [31:0] addr,
        input int          nregs
    );
        return addr < 32'(nregs);
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One registered read port: range/R0 masking, write bypass, busy report.
// Ports: clk, rst, run/flush qualifiers, addr, raw array data, busy bit,
// write bus for bypass; outputs rd_data (registered) and rd_busy (comb).
module rf_read_port
    import mcpu_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int NREGS   = 8,
    parameter int R0_ZERO = 0,
    parameter int AW      = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             flush,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] raw_data,
    input  logic             busy_bit,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_busy
);

    logic hit;
    logic ok;

    assign hit = wr_en && (wr_addr == addr);
    assign ok  = addr_valid(32'(addr), NREGS)
              && !((R0_ZERO != 0) && (addr == '0));

    // A completing write is treated as already resolved.
    assign rd_busy = run && ok && busy_bit && !hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (!run || flush || !ok) begin
            rd_data <= '0;
        end else if (hit) begin
            rd_data <= wr_data;
        end else begin
            rd_data <= raw_data;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Register file with NRD read ports, bypassed write, busy scoreboard
// and a clear sequencer. Ports: clk, rst, clr_req, init_done, rd_addr,
// rd_data, rd_busy, wr_en/wr_addr/wr_data, rsv_en/rsv_addr, busy_vec.
module regfile_sb
    import mcpu_pkg::*;
#(
    parameter  int WIDTH   = MCPU_WIDTH,
    parameter  int NREGS   = MCPU_NREGS,
    parameter  int NRD     = 2,
    parameter  int R0_ZERO = 0,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr_req,
    output logic               init_done,
    input  logic [NRD*AW-1:0]  rd_addr,
    output logic [NRD*WIDTH-1:0] rd_data,
    output logic [NRD-1:0]     rd_busy,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               rsv_en,
    input  logic [AW-1:0]      rsv_addr,
    output logic [NREGS-1:0]   busy_vec
);

    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    rf_state_t        state;
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] mem [NREGS];
    logic [NREGS-1:0] busy_nxt;
    logic             run;
    logic             accept;
    logic             wr_ok;
    logic             rsv_ok;

    assign run       = (state == RF_RUN);
    assign init_done = run;
    // A clear request discards any same-cycle write or reservation.
    assign accept    = run && !clr_req;

    assign wr_ok  = accept && wr_en
                 && addr_valid(32'(wr_addr), NREGS)
                 && !((R0_ZERO != 0) && (wr_addr == '0));
    assign rsv_ok = accept && rsv_en
                 && addr_valid(32'(rsv_addr), NREGS)
                 && !((R0_ZERO != 0) && (rsv_addr == '0));

    // Set after clear: a new producer supersedes the completing one.
    always_comb begin
        busy_nxt = busy_vec;
        if (wr_ok) busy_nxt[wr_addr] = 1'b0;
        if (rsv_ok) busy_nxt[rsv_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RF_INIT;
            idx      <= '0;
            busy_vec <= '0;
        end else begin
            unique case (state)
                RF_INIT: begin
                    busy_vec <= '0;
                    if (idx == LAST) begin
                        state <= RF_RUN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                RF_RUN: begin
                    if (clr_req) begin
                        state    <= RF_INIT;
                        idx      <= '0;
                        busy_vec <= '0;
                    end else begin
                        busy_vec <= busy_nxt;
                    end
                end
            endcase
        end
    end

    // Storage is not reset; the INIT sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (state == RF_INIT) begin
            mem[idx] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_port
        logic [AW-1:0]    a;
        logic [WIDTH-1:0] raw;
        logic             bsy;

        assign a   = rd_addr[p*AW +: AW];
        assign raw = addr_valid(32'(a), NREGS) ? mem[a] : '0;
        assign bsy = addr_valid(32'(a), NREGS) ? busy_vec[a] : 1'b0;

        rf_read_port #(
            .WIDTH   (WIDTH),
            .NREGS   (NREGS),
            .R0_ZERO (R0_ZERO),
            .AW      (AW)
        ) u_port (
            .clk      (clk),
            .rst      (rst),
            .run      (run),
            .flush    (clr_req),
            .addr     (a),
            .raw_data (raw),
            .busy_bit (bsy),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[p*WIDTH +: WIDTH]),
            .rd_busy  (rd_busy[p])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two configurations share one stimulus stream.
// A: 16b x 8 regs, 2 ports, R0 normal. B: 32b x 6 regs, 3 ports, R0 zero.
module tb_regfile_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        clr_req;
    logic        wr_en;
    logic        rsv_en;
    logic [2:0]  wr_addr;
    logic [2:0]  rsv_addr;
    logic [31:0] wr_data;
    logic [2:0]  ra [3];

    logic [5:0]  rd_addr_a;
    logic [8:0]  rd_addr_b;
    logic [31:0] rd_data_a;
    logic [95:0] rd_data_b;
    logic [1:0]  rd_busy_a;
    logic [2:0]  rd_busy_b;
    logic [7:0]  busy_a;
    logic [5:0]  busy_b;
    logic        init_a;
    logic        init_b;

    assign rd_addr_a = {ra[1], ra[0]};
    assign rd_addr_b = {ra[2], ra[1], ra[0]};

    regfile_sb #(
        .WIDTH(16), .NREGS(8), .NRD(2), .R0_ZERO(0)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .init_done (init_a),
        .rd_addr   (rd_addr_a),
        .rd_data   (rd_data_a),
        .rd_busy   (rd_busy_a),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data[15:0]),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .busy_vec  (busy_a)
    );

    regfile_sb #(
        .WIDTH(32), .NREGS(6), .NRD(3), .R0_ZERO(1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .clr_req   (clr_req),
        .init_done (init_b),
        .rd_addr   (rd_addr_b),
        .rd_data   (rd_data_b),
        .rd_busy   (rd_busy_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .busy_vec  (busy_b)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model, index c: 0 = config A, 1 = config B.
    logic [31:0] mm   [2][8];
    logic [7:0]  mb   [2];
    bit          mrun [2];
    int          midx [2];
    logic [31:0] erd  [2][3];

    function automatic int nregs_of(input int c);
        return (c == 0) ? 8 : 6;
    endfunction

    function automatic int nrd_of(input int c);
        return (c == 0) ? 2 : 3;
    endfunction

    function automatic bit mvalid(input int c, input logic [2:0] a);
        return (int'(a) < nregs_of(c)) && !(c == 1 && a == 3'd0);
    endfunction

    function automatic logic [31:0] wd_of(input int c);
        return (c == 0) ? {16'h0, wr_data[15:0]} : wr_data;
    endfunction

    function automatic logic [31:0] obs_rd(input int c, input int p);
        if (c == 0) return {16'h0, rd_data_a[p*16 +: 16]};
        return rd_data_b[p*32 +: 32];
    endfunction

    function automatic logic obs_busy(input int c, input int p);
        if (c == 0) return rd_busy_a[p];
        return rd_busy_b[p];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            mrun[c] = 1'b0;
            midx[c] = 0;
            mb[c]   = 8'h0;
            for (int p = 0; p < 3; p++) erd[c][p] = 32'h0;
        end
    endtask

    task automatic model_edge();
        for (int c = 0; c < 2; c++) begin
            if (!mrun[c]) begin
                mm[c][midx[c]] = 32'h0;
                midx[c]++;
                if (midx[c] == nregs_of(c)) mrun[c] = 1'b1;
                for (int p = 0; p < 3; p++) erd[c][p] = 32'h0;
            end else if (clr_req) begin
                mrun[c] = 1'b0;
                midx[c] = 0;
                mb[c]   = 8'h0;
                for (int p = 0; p < 3; p++) erd[c][p] = 32'h0;
            end else begin
                for (int p = 0; p < nrd_of(c); p++) begin
                    if (!mvalid(c, ra[p])) erd[c][p] = 32'h0;
                    else if (wr_en && wr_addr == ra[p]) erd[c][p] = wd_of(c);
                    else erd[c][p] = mm[c][ra[p]];
                end
                if (wr_en && mvalid(c, wr_addr)) begin
                    mm[c][wr_addr] = wd_of(c);
                    mb[c][wr_addr] = 1'b0;
                end
                if (rsv_en && mvalid(c, rsv_addr)) mb[c][rsv_addr] = 1'b1;
            end
        end
    endtask

    task automatic check_comb();
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < nrd_of(c); p++) begin
                chk($sformatf("rd_busy%0d_%0d", c, p),
                    32'(obs_busy(c, p)),
                    32'(mrun[c] && mvalid(c, ra[p]) && mb[c][ra[p]]
                        && !(wr_en && wr_addr == ra[p])));
            end
        end
    endtask

    task automatic check_reg();
        chk("init_a", 32'(init_a), 32'(mrun[0]));
        chk("init_b", 32'(init_b), 32'(mrun[1]));
        chk("busy_a", 32'(busy_a), 32'(mb[0]));
        chk("busy_b", 32'(busy_b), 32'(mb[1][5:0]));
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < nrd_of(c); p++) begin
                chk($sformatf("rd_data%0d_%0d", c, p), obs_rd(c, p), erd[c][p]);
            end
        end
    endtask

    // Inputs are set at a falling edge; this runs one full clock.
    task automatic cycle();
        #1;
        check_comb();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_reg();
    endtask

    task automatic idle();
        wr_en   = 1'b0;
        rsv_en  = 1'b0;
        clr_req = 1'b0;
    endtask

    task automatic set_ra(input logic [2:0] a0, input logic [2:0] a1,
                          input logic [2:0] a2);
        ra[0] = a0;
        ra[1] = a1;
        ra[2] = a2;
    endtask

    task automatic write(input logic [2:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic read_all();
        idle();
        for (int a = 0; a < 8; a++) begin
            set_ra(3'(a), 3'(7 - a), 3'(a));
            cycle();
        end
    endtask

    initial begin
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 8; i++) mm[c][i] = $urandom;
        idle();
        wr_addr  = 3'd0;
        rsv_addr = 3'd0;
        wr_data  = 32'h0;
        set_ra(3'd0, 3'd0, 3'd0);

        // Reset state.
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        check_reg();
        rst = 1'b0;

        // INIT sweep with writes that must be ignored by config A.
        for (int i = 0; i < 8; i++) begin
            write(3'(i), 32'hDEAD_0000 | 32'(i));
            cycle();
            if (i == 6) chk("init_a_7", 32'(init_a), 32'h0);
        end
        chk("init_a_8", 32'(init_a), 32'h1);
        read_all();

        // Write then dual-port read of the same register.
        write(3'd3, 32'hCAFE_BEEF);
        cycle();
        idle();
        set_ra(3'd3, 3'd3, 3'd3);
        cycle();
        chk("dual_rd_a0", obs_rd(0, 0), 32'h0000_BEEF);
        chk("dual_rd_a1", obs_rd(0, 1), 32'h0000_BEEF);

        // Bypass: read and write of reg5 in the same cycle.
        write(3'd5, 32'h0000_1234);
        set_ra(3'd5, 3'd3, 3'd5);
        cycle();
        chk("bypass_a0", obs_rd(0, 0), 32'h0000_1234);

        // Scoreboard: reserve, then complete.
        idle();
        rsv_en   = 1'b1;
        rsv_addr = 3'd2;
        cycle();
        chk("rsv2_vec", 32'(busy_a[2]), 32'h1);
        idle();
        set_ra(3'd2, 3'd2, 3'd2);
        cycle();
        write(3'd2, 32'h0000_0042);
        #1;
        chk("wr2_busy_lo", 32'(rd_busy_a[0]), 32'h0);
        cycle();
        chk("wr2_vec", 32'(busy_a[2]), 32'h0);
        write(3'd4, 32'h0000_5555);
        rsv_en   = 1'b1;
        rsv_addr = 3'd4;
        cycle();
        chk("rsv_wins", 32'(busy_a[4]), 32'h1);

        // Register 0: normal in A, hardwired zero in B.
        write(3'd0, 32'h0000_FFFF);
        rsv_en   = 1'b1;
        rsv_addr = 3'd0;
        cycle();
        idle();
        set_ra(3'd0, 3'd0, 3'd0);
        cycle();
        chk("r0_a", obs_rd(0, 0), 32'h0000_FFFF);
        chk("r0_b", obs_rd(1, 0), 32'h0);
        chk("r0_b_busy", 32'(busy_b[0]), 32'h0);

        // Out-of-range address in B and three distinct ports.
        write(3'd7, 32'h7777_7777);
        cycle();
        write(3'd1, 32'h1111_0001);
        cycle();
        write(3'd2, 32'h2222_0002);
        cycle();
        write(3'd5, 32'h5555_0005);
        cycle();
        idle();
        set_ra(3'd1, 3'd2, 3'd5);
        cycle();
        chk("b_p1", obs_rd(1, 1), 32'h2222_0002);
        chk("b_p2", obs_rd(1, 2), 32'h5555_0005);
        set_ra(3'd7, 3'd7, 3'd7);
        cycle();
        chk("b_oob", obs_rd(1, 0), 32'h0);

        // Clear request with loaded regs and busy bits.
        rsv_en   = 1'b1;
        rsv_addr = 3'd1;
        cycle();
        clr_req  = 1'b1;
        write(3'd6, 32'h6666_6666);
        rsv_en   = 1'b1;
        rsv_addr = 3'd3;
        cycle();
        chk("clr_busy", 32'(busy_a), 32'h0);
        idle();
        for (int i = 0; i < 8; i++) cycle();
        chk("clr_done", 32'(init_a), 32'h1);
        read_all();

        // Async reset in the middle of a clear sweep.
        clr_req = 1'b1;
        cycle();
        idle();
        repeat (3) cycle();
        #2 rst = 1'b1;
        #1 model_reset();
        check_reg();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reg();
        for (int i = 0; i < 8; i++) cycle();
        chk("rst_done", 32'(init_a), 32'h1);
        read_all();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            wr_en    = 1'($urandom_range(0, 1));
            rsv_en   = ($urandom_range(0, 2) == 0);
            clr_req  = ($urandom_range(0, 39) == 0);
            wr_addr  = 3'($urandom_range(0, 7));
            rsv_addr = 3'($urandom_range(0, 7));
            wr_data  = $urandom;
            set_ra(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                   3'($urandom_range(0, 7)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the CPU register file. It provides NRD registered read ports, one write port with write-to-read bypass, and an optional hardwired-zero register 0. It adds a busy-bit scoreboard so multi-cycle or pipelined MCPU variants can detect pending producers, and a clear sequencer that zeroes the array after reset or on request. It sits between the MCPU stage controller (decode, execute and writeback) and the ALU operand muxes.

Parameters:
WIDTH, 16, data width of each register
NREGS, 8, number of registers (>=2; need not be a power of 2)
NRD, 2, number of read ports (>=1)
R0_ZERO, 0, 1 = register 0 reads as 0, and writes/reservations to it are ignored
AW, $clog2(NREGS), address width (localparam, derived)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
clr_req  in  1  pulse: re-run the clear sequence (honoured only in RUN)
init_done  out  1  1 = array valid and ports operational
rd_addr  in  NRD*AW  read addresses; port p = bits [p*AW +: AW]
rd_data  out  NRD*WIDTH  registered read data; port p = [p*WIDTH +: WIDTH]
rd_busy  out  NRD  combinational: addressed register has a pending producer
wr_en  in  1  write strobe
wr_addr  in  AW  write address
wr_data  in  WIDTH  write data
rsv_en  in  1  reserve: mark rsv_addr busy
rsv_addr  in  AW  reservation address
busy_vec  out  NREGS  current scoreboard bits

Behaviour:
- Reset (async):
  - state=INIT, clear index=0, busy_vec=0, rd_data=0, init_done=0.
  - The array itself is not reset; the clear sequencer zeroes it.
- FSM states:
  - INIT: each rising edge writes 0 to reg[idx], then idx++. After the edge that writes reg[NREGS-1], go to RUN and set init_done=1, i.e. exactly NREGS edges after reset deassert.
  - RUN: normal operation. clr_req=1 at an edge -> INIT with idx=0, busy_vec=0, init_done=0 from the next cycle; any wr_en/rsv_en in that same cycle is discarded.
- In INIT: wr_en and rsv_en are ignored, rd_data is held at 0, rd_busy=0. clr_req is ignored in INIT (no restart).
- Read:
  - 1-cycle latency: rd_data[p] at edge k+1 = reg[rd_addr[p]] as sampled at edge k.
  - Bypass: if wr_en && wr_addr==rd_addr[p] at edge k, rd_data[p]=wr_data (new value, not old).
  - Ports are independent; any number of ports may share an address.
- Address rules:
  - Address >= NREGS: reads return 0, writes and reservations are ignored.
  - R0_ZERO=1: address 0 reads 0, never busy, writes and reservations ignored, no bypass.
- Write: reg[wr_addr] <= wr_data at the edge (RUN only).
- Scoreboard, per edge in RUN:
  - rsv_en sets busy[rsv_addr].
  - wr_en clears busy[wr_addr].
  - Same address in the same cycle: set wins (a new producer supersedes the completing one).
- rd_busy[p] = busy[rd_addr[p]] & ~(wr_en && wr_addr==rd_addr[p]). A completing write counts as not busy, consistent with the bypass.
- Mid-operation rst: async abort to INIT; partially updated contents are irrelevant because a full clear follows.

Decomposition:
- Package mcpu_pkg:
  - typedef rf_state_t {RF_INIT, RF_RUN}.
  - Default constants MCPU_WIDTH=16, MCPU_NREGS=8.
  - Helper function addr_valid(addr, nregs).
- Sub-module rf_read_port: a single registered read port containing the bypass compare, R0/range masking and rd_busy logic. It is instantiated NRD times by a generate loop.
- Array, scoreboard and clear FSM stay in the top module.

Test Plan:
- Reset, NREGS=8 -> init_done=0 for 8 edges, =1 after the 8th; all 8 regs then read 0x0000; wr_en pulsed during INIT has no effect.
- Write reg3=0xBEEF; next cycle port0=3, port1=3 -> both rd_data=0xBEEF one cycle later; write reg5=0x1234 while port0 reads 5 in the same cycle -> rd_data0=0x1234 (bypass).
- Scoreboard: rsv reg2 -> busy_vec[2]=1 and rd_busy=1 for a port addressing 2. wr reg2=0x0042 -> rd_busy=0 during the write cycle, busy cleared after the edge. rsv_en+wr_en to reg4 in the same cycle -> busy_vec[4]=1.
- R0_ZERO=1: write reg0=0xFFFF and rsv reg0 -> reads 0, busy_vec[0]=0. R0_ZERO=0: reg0 reads 0xFFFF.
- NREGS=6, WIDTH=32, NRD=3: write addr 7 is ignored and read addr 7 returns 0; three ports reading 1, 2 and 5 return the correct distinct values.
- clr_req in RUN with regs loaded and busy bits set -> init_done=0 for 6 cycles, busy_vec=0, all regs 0 afterwards. Assert rst mid-INIT -> idx restarts at 0 and a full clear completes.
